// File: rtl/simd_accum_dump.sv
// SIMD integrate-and-dump accumulator.
// Sums ACC_LEN accepted beats per lane, with no carry crossing between lanes.
// Each lane is LANE_W-bit signed two's complement.
// Completed sums and sticky overflow flags go out through a valid/ready
// output register.
// Lane packing follows the DSP SIMD layout: lane k sits at [k*LANE_W +: LANE_W].

module simd_accum_dump #(
    parameter int unsigned LANES    = 2,
    parameter int unsigned LANE_W   = 24,
    parameter int unsigned ACC_LEN  = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      clr_i,
    input  logic [LANES*LANE_W-1:0]   s_data_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [LANES*LANE_W-1:0]   m_data_o,
    output logic [LANES-1:0]          m_ovf_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i
);

    localparam int unsigned DataW = LANES * LANE_W;
    localparam int unsigned CntW  = $clog2(ACC_LEN);

    localparam logic [CntW-1:0]   CntLast = CntW'(ACC_LEN - 1);
    localparam logic [LANE_W-1:0] LaneMax = {1'b0, {(LANE_W - 1){1'b1}}};
    localparam logic [LANE_W-1:0] LaneMin = {1'b1, {(LANE_W - 1){1'b0}}};

    // Elaboration-time parameter legality.
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("simd_accum_dump: LANES must be 1, 2 or 4");
    end
    if (LANES * LANE_W > 48) begin : g_bad_width
        $error("simd_accum_dump: LANES*LANE_W must not exceed 48");
    end
    if (ACC_LEN < 2) begin : g_bad_len
        $error("simd_accum_dump: ACC_LEN must be at least 2");
    end

    // Frame state.
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic [LANES-1:0][LANE_W-1:0]  acc_q, acc_d;
    logic [LANES-1:0]              ovf_q, ovf_d;

    // Output register.
    logic [DataW-1:0]              m_data_q, m_data_d;
    logic [LANES-1:0]              m_ovf_q, m_ovf_d;
    logic                          m_valid_q, m_valid_d;

    // Per-lane datapath.
    logic [LANES-1:0][LANE_W-1:0]  base_w;
    logic [LANES-1:0][LANE_W-1:0]  x_w;
    logic [LANES-1:0][LANE_W-1:0]  raw_w;
    logic [LANES-1:0][LANE_W-1:0]  sum_w;
    logic [LANES-1:0]              add_ovf_w;
    logic [LANES-1:0]              ovf_acc_w;

    logic                          first_beat;
    logic                          last_beat;
    logic                          s_ready;
    logic                          beat_acc;
    logic                          dump;

    // Handshake decode: only the closing beat of a frame can stall, and only
    // while the previous dump is still waiting downstream.
    always_comb begin
        first_beat = (cnt_q == '0);
        last_beat  = (cnt_q == CntLast);
        s_ready    = !(last_beat && m_valid_q && !m_ready_i);
        // A beat coinciding with clr_i is dropped even though it handshakes.
        beat_acc   = s_valid_i && s_ready && !clr_i;
        dump       = beat_acc && last_beat;
    end

    // Independent per-lane add with signed overflow detect and optional clamp.
    always_comb begin
        base_w    = '0;
        x_w       = '0;
        raw_w     = '0;
        sum_w     = '0;
        add_ovf_w = '0;
        ovf_acc_w = '0;
        for (int k = 0; k < LANES; k++) begin
            // Beat 0 restarts the frame, so the stale sum is never consumed.
            base_w[k] = first_beat ? '0 : acc_q[k];
            x_w[k]    = s_data_i[k*LANE_W +: LANE_W];
            raw_w[k]  = base_w[k] + x_w[k];
            add_ovf_w[k] = (base_w[k][LANE_W-1] == x_w[k][LANE_W-1]) &&
                           (raw_w[k][LANE_W-1] != x_w[k][LANE_W-1]);
            if (SATURATE && add_ovf_w[k]) begin
                // Operands share a sign here, so x's sign picks the rail.
                sum_w[k] = x_w[k][LANE_W-1] ? LaneMin : LaneMax;
            end else begin
                sum_w[k] = raw_w[k];
            end
            ovf_acc_w[k] = (first_beat ? 1'b0 : ovf_q[k]) | add_ovf_w[k];
        end
    end

    // Next-state for the beat counter and the partial sums.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            acc_d = '0;
            ovf_d = '0;
        end else if (beat_acc) begin
            cnt_d = last_beat ? '0 : cnt_q + CntW'(1);
            acc_d = sum_w;
            ovf_d = ovf_acc_w;
        end
    end

    // Next-state for the output register; a fresh dump overrides the drain.
    always_comb begin
        m_data_d  = m_data_q;
        m_ovf_d   = m_ovf_q;
        m_valid_d = m_valid_q;
        if (dump) begin
            m_data_d  = sum_w;
            m_ovf_d   = ovf_acc_w;
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    // Frame state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            acc_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_data_q  <= '0;
            m_ovf_q   <= '0;
            m_valid_q <= 1'b0;
        end else begin
            m_data_q  <= m_data_d;
            m_ovf_q   <= m_ovf_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Port drive.
    always_comb begin
        s_ready_o = s_ready;
        m_data_o  = m_data_q;
        m_ovf_o   = m_ovf_q;
        m_valid_o = m_valid_q;
    end

endmodule

// File: tb/tb_simd_accum_dump.sv
// Bench for simd_accum_dump: three instances (wrap, saturate, 4x12 lanes)
// share one 48-bit stimulus stream and are compared against an integer
// reference model of the accumulate/dump behaviour.

module tb_simd_accum_dump;

    localparam int ACC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clr;
    logic        s_valid;
    logic        m_ready;
    logic [47:0] s_data;

    logic        rdy_a, rdy_s, rdy_q;
    logic [47:0] md_a, md_s, md_q;
    logic [1:0]  mo_a, mo_s;
    logic [3:0]  mo_q;
    logic        mv_a, mv_s, mv_q;

    simd_accum_dump #(.LANES(2), .LANE_W(24), .ACC_LEN(ACC), .SATURATE(1'b0)) u_wrap (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(rdy_a), .m_data_o(md_a), .m_ovf_o(mo_a), .m_valid_o(mv_a), .m_ready_i(m_ready)
    );
    simd_accum_dump #(.LANES(2), .LANE_W(24), .ACC_LEN(ACC), .SATURATE(1'b1)) u_sat (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(rdy_s), .m_data_o(md_s), .m_ovf_o(mo_s), .m_valid_o(mv_s), .m_ready_i(m_ready)
    );
    simd_accum_dump #(.LANES(4), .LANE_W(12), .ACC_LEN(ACC), .SATURATE(1'b0)) u_quad (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(rdy_q), .m_data_o(md_q), .m_ovf_o(mo_q), .m_valid_o(mv_q), .m_ready_i(m_ready)
    );

    int total = 0;
    int bad   = 0;

    // Per-instance configuration.
    int unsigned nl [3] = '{2, 2, 4};
    int unsigned lw [3] = '{24, 24, 12};
    bit          sat[3] = '{1'b0, 1'b1, 1'b0};

    // Reference model state: running sums as plain integers.
    int     m_cnt[3];
    longint m_acc[3][4];
    bit     m_ov [3][4];
    bit     m_mv [3];
    longint m_od [3][4];
    bit     m_oo [3][4];

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint lane_val(input logic [47:0] d, input int c, input int k);
        logic [47:0] sh;
        longint      raw;
        longint      half;
        sh   = (d >> (k * lw[c])) & ((48'd1 << lw[c]) - 48'd1);
        raw  = longint'({16'd0, sh});
        half = longint'(1) << (lw[c] - 1);
        if (raw >= half) raw = raw - 2 * half;
        return raw;
    endfunction

    function automatic longint wrapv(input longint t, input int c);
        longint m;
        longint r;
        m = longint'(1) << lw[c];
        r = t % m;
        if (r < 0) r = r + m;
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    function automatic logic [47:0] exp_data(input int c);
        logic [47:0] r;
        logic [47:0] mask;
        r    = '0;
        mask = (48'd1 << lw[c]) - 48'd1;
        for (int k = 0; k < int'(nl[c]); k++) begin
            r = r | ((48'(m_od[c][k]) & mask) << (k * lw[c]));
        end
        return r;
    endfunction

    function automatic logic [47:0] exp_ovf(input int c);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < int'(nl[c]); k++) r[k] = m_oo[c][k];
        return r;
    endfunction

    function automatic bit model_ready(input int c);
        return !(m_cnt[c] == ACC - 1 && m_mv[c] && !m_ready);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_cnt[c] = 0;
            m_mv[c]  = 1'b0;
            for (int k = 0; k < 4; k++) begin
                m_acc[c][k] = 0;
                m_ov[c][k]  = 1'b0;
                m_od[c][k]  = 0;
                m_oo[c][k]  = 1'b0;
            end
        end
    endtask

    // One clock edge of the specified behaviour, using the current inputs.
    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            bit     dump;
            longint maxv;
            longint minv;
            dump = 1'b0;
            maxv = (longint'(1) << (lw[c] - 1)) - 1;
            minv = -(longint'(1) << (lw[c] - 1));
            if (clr) begin
                m_cnt[c] = 0;
                for (int k = 0; k < 4; k++) begin
                    m_acc[c][k] = 0;
                    m_ov[c][k]  = 1'b0;
                end
            end else if (s_valid && model_ready(c)) begin
                for (int k = 0; k < int'(nl[c]); k++) begin
                    longint base;
                    longint t;
                    bit     o;
                    base = (m_cnt[c] == 0) ? 0 : m_acc[c][k];
                    t    = base + lane_val(s_data, c, k);
                    o    = (t > maxv) || (t < minv);
                    if (sat[c]) m_acc[c][k] = (t > maxv) ? maxv : ((t < minv) ? minv : t);
                    else        m_acc[c][k] = wrapv(t, c);
                    m_ov[c][k] = ((m_cnt[c] == 0) ? 1'b0 : m_ov[c][k]) | o;
                end
                if (m_cnt[c] == ACC - 1) begin
                    dump     = 1'b1;
                    m_cnt[c] = 0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            if (dump) begin
                m_mv[c] = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    m_od[c][k] = m_acc[c][k];
                    m_oo[c][k] = m_ov[c][k];
                end
            end else if (m_mv[c] && m_ready) begin
                m_mv[c] = 1'b0;
            end
        end
    endtask

    task automatic check_ready(input string tag);
        logic r;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0:       r = rdy_a;
                1:       r = rdy_s;
                default: r = rdy_q;
            endcase
            chk($sformatf("%s/i%0d/s_ready", tag, c), 48'(r), 48'(model_ready(c)));
        end
    endtask

    task automatic check_out(input string tag);
        logic        v;
        logic [47:0] d;
        logic [47:0] o;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0:       begin v = mv_a; d = md_a; o = 48'(mo_a); end
                1:       begin v = mv_s; d = md_s; o = 48'(mo_s); end
                default: begin v = mv_q; d = md_q; o = 48'(mo_q); end
            endcase
            chk($sformatf("%s/i%0d/m_valid", tag, c), 48'(v), 48'(m_mv[c]));
            chk($sformatf("%s/i%0d/m_data", tag, c), d, exp_data(c));
            chk($sformatf("%s/i%0d/m_ovf", tag, c), o, exp_ovf(c));
        end
    endtask

    // Drive one cycle: set inputs, check s_ready, advance model and clock.
    task automatic step(input bit v, input logic [47:0] d, input bit cl, input bit mr,
                        input string tag);
        s_valid = v;
        s_data  = d;
        clr     = cl;
        m_ready = mr;
        #1;
        check_ready(tag);
        model_edge();
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        logic [47:0] d;

        rst_n   = 1'b0;
        clr     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        s_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out("reset");
        rst_n = 1'b1;
        #1;
        check_ready("reset");

        // Basic sum: lane0 = 1..4, lane1 = -1.
        for (int i = 1; i <= 4; i++) step(1'b1, {24'hFFFFFF, 24'(i)}, 1'b0, 1'b1, "basic");
        chk("basic/const_data", md_a, 48'hFFFFFC_00000A);
        chk("basic/const_ovf", 48'(mo_a), 48'd0);
        chk("basic/const_valid", 48'(mv_a), 48'd1);

        // Wrap vs saturation with lane isolation.
        for (int i = 0; i < 4; i++) step(1'b1, 48'h000000_400000, 1'b0, 1'b1, "wrap");
        chk("wrap/const_data", md_a, 48'h000000_000000);
        chk("wrap/const_ovf", 48'(mo_a), 48'd1);
        chk("sat/const_data", md_s, 48'h000000_7FFFFF);
        chk("sat/const_ovf", 48'(mo_s), 48'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 48'h000000_000001, 1'b0, 1'b1, "sat_next");
        chk("sat_next/const_data", md_s, 48'd4);
        chk("sat_next/const_ovf", 48'(mo_s), 48'd0);
        step(1'b0, '0, 1'b0, 1'b1, "idle");

        // Backpressure: eight beats 1..8 with downstream stalled.
        for (int i = 1; i <= 7; i++) step(1'b1, 48'(i), 1'b0, 1'b0, "bp_fill");
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 48'd8, 1'b0, 1'b0, "bp_stall");
            chk("bp_stall/const_ready", 48'(rdy_a), 48'd0);
            chk("bp_stall/const_hold", md_a, 48'd10);
        end
        step(1'b1, 48'd8, 1'b0, 1'b1, "bp_release");
        chk("bp_release/const_valid", 48'(mv_a), 48'd1);
        chk("bp_release/const_data", md_a, 48'd26);
        step(1'b0, '0, 1'b0, 1'b1, "bp_drain");

        // Abort with a dump pending downstream.
        for (int i = 0; i < 4; i++) step(1'b1, 48'd3, 1'b0, 1'b0, "ab_pend");
        step(1'b1, 48'd5, 1'b0, 1'b0, "ab_5");
        step(1'b1, 48'd5, 1'b0, 1'b0, "ab_5");
        step(1'b1, 48'd7, 1'b1, 1'b0, "ab_clr");
        chk("ab_clr/const_valid", 48'(mv_a), 48'd1);
        chk("ab_clr/const_data", md_a, 48'd12);
        step(1'b0, '0, 1'b0, 1'b1, "ab_drain");
        for (int i = 0; i < 4; i++) step(1'b1, 48'd1, 1'b0, 1'b1, "ab_ones");
        chk("ab_ones/const_data", md_a, 48'd4);

        // Asynchronous reset mid-frame with a dump pending.
        for (int i = 0; i < 4; i++) step(1'b1, 48'h001_001_001_001, 1'b0, 1'b0, "rs_pend");
        for (int i = 0; i < 3; i++) step(1'b1, 48'h001_001_001_001, 1'b0, 1'b0, "rs_part");
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_out("rs_async");
        chk("rs_async/const_valid", 48'(mv_q), 48'd0);
        chk("rs_async/const_data", md_q, 48'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_ready("rs_release");
        for (int i = 0; i < 4; i++) step(1'b1, 48'h003_002_001_000, 1'b0, 1'b1, "quad");
        chk("quad/const_data", md_q, 48'h00C_008_004_000);
        chk("quad/const_ovf", 48'(mo_q), 48'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            d  = {r1[15:0], r2};
            if ($urandom_range(0, 1) == 0) d = d & 48'h00F00F_00F00F;
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
